fpu_issue_queue: RTL and testbench
==================================

FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

Interface
REQ-001 Parameter LAT, default 4: fixed fpu latency in clock edges, operand presentation to valid fpu out.
REQ-002 Parameter DEPTH, default 4: result FIFO entries; also the maximum number of requests in flight plus buffered.
REQ-003 Parameter TAG_W, default 4: request tag width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid / req_ready  in / out  1 / 1  request handshake.
REQ-007 req_op  in  3  operation: 0 add, 1 sub, 2 mul, 3 div, 4-7 illegal.
REQ-008 req_rmode  in  2  rounding mode, passed through to the fpu.
REQ-009 req_opa, req_opb  in  32  IEEE-754 single operands.
REQ-010 req_tag  in  TAG_W  opaque tag, returned with the result.
REQ-011 fpu_op, fpu_rmode, fpu_opa, fpu_opb  out  3, 2, 32, 32  registered drive to the fpu.
REQ-012 fpu_out  in  32  fpu result; fpu_flags  in  8  {snan,qnan,inf,ine,overflow,underflow,div_by_zero,zero}, bit 7..0.
REQ-013 rsp_valid / rsp_ready  out / in  1 / 1  result handshake.
REQ-014 rsp_out  out  32; rsp_flags  out  8; rsp_tag  out  TAG_W.
REQ-015 busy  out  1  high while any request is in flight or buffered.

Function
REQ-016 req_ready = (inflight + fifo_count) < DEPTH; purely combinational from state, independent of req_valid.
REQ-017 On accept (req_valid & req_ready), fpu_* ports register the request at that edge; the edge is stage 0 of the slot.
REQ-018 A LAT-stage valid/tag/illegal shift register advances every cycle; the slot completes at stage LAT and pushes {fpu_out, fpu_flags, tag} into the FIFO the same edge.
REQ-019 Illegal op: fpu_op driven 0; result substituted at completion with 32'h7FC00000 and flags 8'h40; order preserved.
REQ-020 With no accept, fpu_* ports hold their last value.
REQ-021 Results are delivered strictly in acceptance order; one accept and one completion per cycle maximum.
REQ-022 The FIFO never overflows: the credit rule in REQ-016 guarantees space at completion regardless of rsp_ready.
REQ-023 rsp_* present the FIFO head while rsp_valid; held stable until rsp_ready; pop on rsp_valid & rsp_ready.
REQ-024 Simultaneous accept, completion and pop in one cycle are all legal; the count updates by net effect.
REQ-025 Full credit (count = DEPTH) with a same-cycle pop: req_ready stays low that cycle and rises the next.
REQ-026 Minimum latency, accept to rsp_valid: LAT+1 edges (FIFO registered output).
REQ-027 Back-to-back accepts with rsp_ready high sustain one result per cycle.

Reset
REQ-028 rst_n low clears the shift register valids, the FIFO pointers and counts; rsp_valid=0, busy=0, req_ready=1 after release.
REQ-029 fpu_op=0, fpu_rmode=0, fpu_opa=0, fpu_opb=0, rsp_out=0, rsp_flags=0, rsp_tag=0 on reset.
REQ-030 Reset mid-operation discards all in-flight and buffered results; nothing is emitted after release until new accepts.

Structure
REQ-031 Shared package holds the op encodings, the flag bit indices, and QNAN_CONST 32'h7FC00000.
REQ-032 One sub-module: fpu_result_fifo (synchronous FIFO, DEPTH x (40+TAG_W), registered output).
REQ-033 The fpu instance sits outside this block; this block only drives and samples its ports.

Verification
REQ-034 Add rmode 0, opa 41C00000 (24), opb 41200000 (10), tag 1 -> rsp_out 42080000, flags 00, tag 1.
REQ-035 Four back-to-back: sub, mul, div, add of 24,10 -> 41600000, 43700000, 4019999A, 42080000 in order, consecutive cycles.
REQ-036 Div 3F800000 / 00000000 -> rsp_out 7F800000, div_by_zero and inf set.
REQ-037 rsp_ready held low, 6 requests offered -> exactly 4 accepted, req_ready low; first pop re-enables acceptance next cycle, no loss.
REQ-038 req_op 5 between two adds -> middle result 7FC00000, flags 40; tag order intact.
REQ-039 rst_n pulsed low with 3 in flight -> no rsp_valid afterward; busy 0; the next request completes normally.

Source files
------------

// File: rtl/fpu_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// fpu_issue_queue_pkg
// Shared definitions for the FPU issue queue: operation encodings, the bit
// positions of the fpu status flags, and the values substituted into the
// result of an illegal operation.
// -----------------------------------------------------------------------------
package fpu_issue_queue_pkg;

    // Operation encodings understood by the fpu; 4..7 are illegal.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3
    } fpu_op_e;

    // Bit positions inside the 8-bit fpu flag vector.
    localparam int unsigned FLAG_SNAN        = 7;
    localparam int unsigned FLAG_QNAN        = 6;
    localparam int unsigned FLAG_INF         = 5;
    localparam int unsigned FLAG_INE         = 4;
    localparam int unsigned FLAG_OVERFLOW    = 3;
    localparam int unsigned FLAG_UNDERFLOW   = 2;
    localparam int unsigned FLAG_DIV_BY_ZERO = 1;
    localparam int unsigned FLAG_ZERO        = 0;

    // Result substituted for an illegal operation: canonical quiet NaN with
    // only the qnan flag raised.
    localparam logic [31:0] QNAN_CONST    = 32'h7FC0_0000;
    localparam logic [7:0]  ILLEGAL_FLAGS = 8'h40;

    // An operation is legal when it is one of the four encodings above.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// -----------------------------------------------------------------------------
// fpu_result_fifo
// Synchronous FIFO with a registered head. The head register is what the
// consumer sees; the storage array holds the entries behind it. When the FIFO
// is empty a pushed entry goes straight into the head register, so data
// pushed at an edge is visible right after that edge.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i this edge (caller guarantees space)
//   push_data_i     entry to store
//   pop_ready_i     consumer ready; head is popped when valid_o & pop_ready_i
//   valid_o         head register holds a valid entry
//   data_o          head entry (zero after reset)
//   count_o         total entries held, head included
// -----------------------------------------------------------------------------
module fpu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 44,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_ready_i,
    output logic             valid_o,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic             head_valid_q, head_valid_d;
    logic [W-1:0]     head_data_q, head_data_d;

    logic pop_s;
    logic load_head_s;
    logic head_from_mem_s;
    logic head_from_push_s;
    logic mem_wr_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Head refill and storage pointer bookkeeping.
    always_comb begin
        pop_s            = head_valid_q & pop_ready_i;
        load_head_s      = ~head_valid_q | pop_s;
        // The storage array is only non-empty while the head is valid, so an
        // empty array plus a free head means the push can bypass storage.
        head_from_mem_s  = load_head_s & (mem_cnt_q != '0);
        head_from_push_s = load_head_s & (mem_cnt_q == '0) & push_i;
        mem_wr_s         = push_i & ~head_from_push_s;

        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        if (head_from_mem_s) begin
            head_valid_d = 1'b1;
            head_data_d  = mem_q[rd_ptr_q];
        end else if (head_from_push_s) begin
            head_valid_d = 1'b1;
            head_data_d  = push_data_i;
        end else if (pop_s) begin
            head_valid_d = 1'b0;
        end else begin
            head_valid_d = head_valid_q;
        end

        wr_ptr_d  = mem_wr_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = head_from_mem_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + CNT_W'(mem_wr_s) - CNT_W'(head_from_mem_s);
    end

    // Storage array write port (contents need no reset; pointers gate use).
    always_ff @(posedge clk_i) begin
        if (mem_wr_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer, count and head register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    assign valid_o = head_valid_q;
    assign data_o  = head_data_q;
    assign count_o = mem_cnt_q + CNT_W'(head_valid_q);

endmodule

// File: rtl/fpu_issue_queue.sv
// -----------------------------------------------------------------------------
// fpu_issue_queue
// Issues single-precision requests to an external fixed-latency fpu and
// returns results in acceptance order through a result FIFO. A credit rule
// (in-flight + buffered < DEPTH) guarantees the FIFO always has room when a
// request completes, so completions never need to stall.
//
// Ports
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   req_valid_i / req_ready_o           request handshake
//   req_op_i, req_rmode_i               operation (0..3 legal), rounding mode
//   req_opa_i, req_opb_i, req_tag_i     operands and opaque tag
//   fpu_op_o, fpu_rmode_o,
//   fpu_opa_o, fpu_opb_o                registered drive to the fpu
//   fpu_out_i, fpu_flags_i              fpu result, sampled LAT edges after
//                                       the accept edge
//   rsp_valid_o / rsp_ready_i           result handshake
//   rsp_out_o, rsp_flags_o, rsp_tag_o   result, flags and tag (FIFO head)
//   busy_o                              any request in flight or buffered
// -----------------------------------------------------------------------------
module fpu_issue_queue
    import fpu_issue_queue_pkg::*;
#(
    parameter int unsigned LAT   = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [1:0]       req_rmode_i,
    input  logic [31:0]      req_opa_i,
    input  logic [31:0]      req_opb_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [2:0]       fpu_op_o,
    output logic [1:0]       fpu_rmode_o,
    output logic [31:0]      fpu_opa_o,
    output logic [31:0]      fpu_opb_o,
    input  logic [31:0]      fpu_out_i,
    input  logic [7:0]       fpu_flags_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_out_o,
    output logic [7:0]       rsp_flags_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);

    localparam int unsigned ENTRY_W = 40 + TAG_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W   = $clog2(LAT + DEPTH + 1);

    // Slot pipeline: bit k is the request accepted k edges ago.
    logic [LAT-1:0]            slot_valid_q, slot_valid_d;
    logic [LAT-1:0]            slot_ill_q, slot_ill_d;
    logic [LAT-1:0][TAG_W-1:0] slot_tag_q, slot_tag_d;

    logic [2:0]  fpu_op_q, fpu_op_d;
    logic [1:0]  fpu_rmode_q, fpu_rmode_d;
    logic [31:0] fpu_opa_q, fpu_opa_d;
    logic [31:0] fpu_opb_q, fpu_opb_d;

    logic               accept_s;
    logic               complete_s;
    logic [31:0]        cpl_result_s;
    logic [7:0]         cpl_flags_s;
    logic [ENTRY_W-1:0] push_data_s;
    logic [SUM_W-1:0]   inflight_s;
    logic [SUM_W-1:0]   credit_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_valid_s;
    logic [ENTRY_W-1:0] fifo_head_s;

    assign accept_s   = req_valid_i & req_ready_o;
    assign complete_s = slot_valid_q[LAT-1];

    // Credit count: requests in the slot pipeline plus entries in the FIFO.
    always_comb begin
        inflight_s = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight_s = inflight_s + SUM_W'(slot_valid_q[k]);
        end
        credit_s = inflight_s + SUM_W'(fifo_count_s);
    end

    assign req_ready_o = (credit_s < SUM_W'(DEPTH));
    assign busy_o      = (credit_s != '0);

    // Slot pipeline advance: stage 0 loads on accept, others shift each edge.
    always_comb begin
        slot_valid_d    = slot_valid_q;
        slot_ill_d      = slot_ill_q;
        slot_tag_d      = slot_tag_q;
        slot_valid_d[0] = accept_s;
        slot_ill_d[0]   = ~op_is_legal(req_op_i);
        slot_tag_d[0]   = req_tag_i;
        for (int k = 1; k < LAT; k++) begin
            slot_valid_d[k] = slot_valid_q[k-1];
            slot_ill_d[k]   = slot_ill_q[k-1];
            slot_tag_d[k]   = slot_tag_q[k-1];
        end
    end

    // fpu drive registers: capture on accept, hold otherwise. Illegal ops are
    // sent as an add so the fpu never sees an undefined encoding.
    always_comb begin
        fpu_op_d    = fpu_op_q;
        fpu_rmode_d = fpu_rmode_q;
        fpu_opa_d   = fpu_opa_q;
        fpu_opb_d   = fpu_opb_q;
        if (accept_s) begin
            fpu_op_d    = op_is_legal(req_op_i) ? req_op_i : OP_ADD;
            fpu_rmode_d = req_rmode_i;
            fpu_opa_d   = req_opa_i;
            fpu_opb_d   = req_opb_i;
        end else begin
            fpu_op_d    = fpu_op_q;
        end
    end

    // Completion data: substitute the quiet NaN for illegal operations.
    always_comb begin
        if (slot_ill_q[LAT-1]) begin
            cpl_result_s = QNAN_CONST;
            cpl_flags_s  = ILLEGAL_FLAGS;
        end else begin
            cpl_result_s = fpu_out_i;
            cpl_flags_s  = fpu_flags_i;
        end
    end

    assign push_data_s = {cpl_result_s, cpl_flags_s, slot_tag_q[LAT-1]};

    // Slot pipeline and fpu drive register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            slot_ill_q   <= '0;
            slot_tag_q   <= '0;
            fpu_op_q     <= 3'd0;
            fpu_rmode_q  <= 2'd0;
            fpu_opa_q    <= 32'd0;
            fpu_opb_q    <= 32'd0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_ill_q   <= slot_ill_d;
            slot_tag_q   <= slot_tag_d;
            fpu_op_q     <= fpu_op_d;
            fpu_rmode_q  <= fpu_rmode_d;
            fpu_opa_q    <= fpu_opa_d;
            fpu_opb_q    <= fpu_opb_d;
        end
    end

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_result_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (complete_s),
        .push_data_i (push_data_s),
        .pop_ready_i (rsp_ready_i),
        .valid_o     (fifo_valid_s),
        .data_o      (fifo_head_s),
        .count_o     (fifo_count_s)
    );

    assign fpu_op_o    = fpu_op_q;
    assign fpu_rmode_o = fpu_rmode_q;
    assign fpu_opa_o   = fpu_opa_q;
    assign fpu_opb_o   = fpu_opb_q;
    assign rsp_valid_o = fifo_valid_s;
    assign rsp_out_o   = fifo_head_s[ENTRY_W-1 -: 32];
    assign rsp_flags_o = fifo_head_s[TAG_W+7 : TAG_W];
    assign rsp_tag_o   = fifo_head_s[TAG_W-1:0];

endmodule

// File: tb/tb_fpu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_queue
// Bench for fpu_issue_queue. A behavioural fpu (fixed latency, table of known
// IEEE results plus a hash for arbitrary operands) drives the fpu ports, and
// a queue of expected responses, each with the cycle it becomes visible,
// predicts rsp/ready/busy behaviour.
// -----------------------------------------------------------------------------
module tb_fpu_issue_queue;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam logic [31:0] F24 = 32'h41C0_0000;
    localparam logic [31:0] F10 = 32'h4120_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [2:0]       req_op_i = 3'd0;
    logic [1:0]       req_rmode_i = 2'd0;
    logic [31:0]      req_opa_i = 32'd0;
    logic [31:0]      req_opb_i = 32'd0;
    logic [TAG_W-1:0] req_tag_i = '0;
    logic [2:0]       fpu_op_o;
    logic [1:0]       fpu_rmode_o;
    logic [31:0]      fpu_opa_o;
    logic [31:0]      fpu_opb_o;
    logic [31:0]      fpu_out_i;
    logic [7:0]       fpu_flags_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic [31:0]      rsp_out_o;
    logic [7:0]       rsp_flags_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             busy_o;

    typedef struct {
        logic [31:0]      out;
        logic [7:0]       flags;
        logic [TAG_W-1:0] tag;
        int               due;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic [39:0] fpu_pipe [LAT-1];

    fpu_issue_queue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_rmode_i (req_rmode_i),
        .req_opa_i   (req_opa_i),
        .req_opb_i   (req_opb_i),
        .req_tag_i   (req_tag_i),
        .fpu_op_o    (fpu_op_o),
        .fpu_rmode_o (fpu_rmode_o),
        .fpu_opa_o   (fpu_opa_o),
        .fpu_opb_o   (fpu_opb_o),
        .fpu_out_i   (fpu_out_i),
        .fpu_flags_i (fpu_flags_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_out_o   (rsp_out_o),
        .rsp_flags_o (rsp_flags_o),
        .rsp_tag_o   (rsp_tag_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural fpu: {flags, result} for an operation.
    function automatic logic [39:0] fpu_ref(input logic [2:0] op, input logic [1:0] rm,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [7:0]  f;
        if (a == F24 && b == F10 && op <= 3'd3) begin
            f = 8'h00;
            case (op)
                3'd0:    r = 32'h4208_0000;
                3'd1:    r = 32'h4160_0000;
                3'd2:    r = 32'h4370_0000;
                default: r = 32'h4019_999A;
            endcase
        end else if (op == 3'd3 && a == 32'h3F80_0000 && b == 32'd0) begin
            r = 32'h7F80_0000;
            f = 8'h22;
        end else begin
            r = a ^ {b[15:0], b[31:16]} ^ {op, rm, 27'd0};
            f = a[7:0] ^ b[31:24] ^ {3'b000, op, rm};
        end
        return {f, r};
    endfunction

    // Result visible LAT-1 edges after the operands are presented, so the
    // queue samples it at the LAT-th edge after acceptance.
    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_ref(fpu_op_o, fpu_rmode_o, fpu_opa_o, fpu_opb_o);
        for (int k = 1; k < LAT - 1; k++) fpu_pipe[k] <= fpu_pipe[k-1];
    end
    assign fpu_out_i   = fpu_pipe[LAT-2][31:0];
    assign fpu_flags_i = fpu_pipe[LAT-2][39:32];

    function automatic exp_t predict(input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a,
                                     input logic [31:0] b, input logic [TAG_W-1:0] tag, input int due);
        exp_t        e;
        logic [39:0] v;
        if (op > 3'd3) begin
            e.out   = 32'h7FC0_0000;
            e.flags = 8'h40;
        end else begin
            v       = fpu_ref(op, rm, a, b);
            e.out   = v[31:0];
            e.flags = v[39:32];
        end
        e.tag = tag;
        e.due = due;
        return e;
    endfunction

    function automatic logic exp_rsp_valid();
        return (q.size() > 0) && (cyc >= q[0].due);
    endfunction

    // Apply the current inputs to the model, then step one clock.
    task automatic advance();
        bit acc;
        acc = req_valid_i && (q.size() < DEPTH);
        if (exp_rsp_valid() && rsp_ready_i) void'(q.pop_front());
        if (acc) q.push_back(predict(req_op_i, req_rmode_i, req_opa_i, req_opb_i, req_tag_i, cyc + 1 + LAT));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [2:0] op, input logic [1:0] rm,
                             input logic [31:0] a, input logic [31:0] b, input int tag);
        req_valid_i = v;
        req_op_i    = op;
        req_rmode_i = rm;
        req_opa_i   = a;
        req_opb_i   = b;
        req_tag_i   = TAG_W'(tag);
    endtask

    task automatic apply_reset();
        drive_req(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 0);
        rsp_ready_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        compared++; if (rsp_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid_o); end
        compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
        compared++; if (req_ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_req_ready got=%0h exp=1", req_ready_o); end
        compared++; if ({fpu_op_o, fpu_rmode_o, fpu_opa_o, fpu_opb_o} !== 69'd0) begin mismatched++;
            $display("FAIL reset_fpu_ports got=%0h/%0h/%0h/%0h exp=0", fpu_op_o, fpu_rmode_o, fpu_opa_o, fpu_opb_o); end
        compared++; if ({rsp_out_o, rsp_flags_o, rsp_tag_o} !== 44'd0) begin mismatched++;
            $display("FAIL reset_rsp_fields got=%0h/%0h/%0h exp=0", rsp_out_o, rsp_flags_o, rsp_tag_o); end
    endtask

    task automatic test_single_add();
        int acc_cyc;
        int n;
        rsp_ready_i = 1'b1;
        drive_req(1'b1, 3'd0, 2'd0, F24, F10, 1);
        advance();
        acc_cyc = cyc;
        req_valid_i = 1'b0;
        compared++; if ({fpu_op_o, fpu_rmode_o} !== 5'd0 || fpu_opa_o !== F24 || fpu_opb_o !== F10) begin mismatched++;
            $display("FAIL add_fpu_drive got=%0h/%0h/%0h/%0h exp=0/0/%0h/%0h", fpu_op_o, fpu_rmode_o, fpu_opa_o, fpu_opb_o, F24, F10); end
        n = 0;
        while (!rsp_valid_o && n < 20) begin advance(); n++; end
        compared++; if (cyc - acc_cyc !== LAT) begin mismatched++; $display("FAIL add_latency got=%0d exp=%0d", cyc - acc_cyc, LAT); end
        compared++; if (rsp_out_o !== 32'h4208_0000 || rsp_flags_o !== 8'h00 || rsp_tag_o !== 4'd1) begin mismatched++;
            $display("FAIL add_result got=%0h/%0h/%0h exp=42080000/0/1", rsp_out_o, rsp_flags_o, rsp_tag_o); end
        advance();
        compared++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin mismatched++;
            $display("FAIL add_drained got valid=%0h busy=%0h exp=0/0", rsp_valid_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops  [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
        logic [31:0] exps [4] = '{32'h4160_0000, 32'h4370_0000, 32'h4019_999A, 32'h4208_0000};
        int acc0;
        int n;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, ops[i], 2'd0, F24, F10, i + 8);
            advance();
            if (i == 0) acc0 = cyc;
        end
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin advance(); n++; end
        compared++; if (cyc !== acc0 + LAT) begin mismatched++; $display("FAIL b2b_first_latency got=%0d exp=%0d", cyc - acc0, LAT); end
        for (int i = 0; i < 4; i++) begin
            compared++; if (rsp_valid_o !== 1'b1 || rsp_out_o !== exps[i] || rsp_flags_o !== 8'h00 || rsp_tag_o !== TAG_W'(i + 8)) begin
                mismatched++;
                $display("FAIL b2b_result_%0d got=%0h/%0h/%0h/%0h exp=1/%0h/0/%0h", i, rsp_valid_o, rsp_out_o, rsp_flags_o, rsp_tag_o, exps[i], i + 8);
            end
            advance();
        end
        compared++; if (rsp_valid_o !== 1'b0) begin mismatched++; $display("FAIL b2b_end_valid got=%0h exp=0", rsp_valid_o); end
    endtask

    task automatic test_div_zero();
        int n;
        rsp_ready_i = 1'b1;
        drive_req(1'b1, 3'd3, 2'd0, 32'h3F80_0000, 32'd0, 2);
        advance();
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin advance(); n++; end
        compared++; if (rsp_valid_o !== 1'b1 || rsp_out_o !== 32'h7F80_0000 || rsp_flags_o !== 8'h22 || rsp_tag_o !== 4'd2) begin mismatched++;
            $display("FAIL div_zero got=%0h/%0h/%0h/%0h exp=1/7f800000/22/2", rsp_valid_o, rsp_out_o, rsp_flags_o, rsp_tag_o); end
        advance();
    endtask

    task automatic test_illegal();
        logic [2:0]  ops  [3] = '{3'd0, 3'd5, 3'd0};
        logic [31:0] exps [3] = '{32'h4208_0000, 32'h7FC0_0000, 32'h4208_0000};
        logic [7:0]  flg  [3] = '{8'h00, 8'h40, 8'h00};
        int n;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, ops[i], 2'd0, F24, F10, i + 3);
            advance();
            if (i == 1) begin
                compared++; if (fpu_op_o !== 3'd0) begin mismatched++; $display("FAIL illegal_fpu_op got=%0h exp=0", fpu_op_o); end
            end
        end
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin advance(); n++; end
        for (int i = 0; i < 3; i++) begin
            compared++; if (rsp_valid_o !== 1'b1 || rsp_out_o !== exps[i] || rsp_flags_o !== flg[i] || rsp_tag_o !== TAG_W'(i + 3)) begin
                mismatched++;
                $display("FAIL illegal_result_%0d got=%0h/%0h/%0h/%0h exp=1/%0h/%0h/%0h", i, rsp_valid_o, rsp_out_o, rsp_flags_o, rsp_tag_o, exps[i], flg[i], i + 3);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int next;
        int got;
        next = 0;
        rsp_ready_i = 1'b0;
        for (int c = 0; c < LAT + 8; c++) begin
            drive_req(next < 6, 3'd0, 2'(next), F24, F10, next);
            if (req_valid_i && req_ready_o) next++;
            advance();
        end
        drive_req(1'b1, 3'd0, 2'(next), F24, F10, next);
        compared++; if (next !== 4) begin mismatched++; $display("FAIL bp_accepted got=%0d exp=4", next); end
        compared++; if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd0) begin mismatched++;
            $display("FAIL bp_full_state got ready=%0h valid=%0h tag=%0h exp=0/1/0", req_ready_o, rsp_valid_o, rsp_tag_o); end
        compared++; if (fpu_rmode_o !== 2'd3) begin mismatched++; $display("FAIL bp_fpu_hold got=%0h exp=3", fpu_rmode_o); end
        rsp_ready_i = 1'b1;
        compared++; if (req_ready_o !== 1'b0) begin mismatched++; $display("FAIL bp_pop_cycle_ready got=%0h exp=0", req_ready_o); end
        got = 1;
        advance();
        compared++; if (req_ready_o !== 1'b1 || rsp_tag_o !== 4'd1) begin mismatched++;
            $display("FAIL bp_after_pop got ready=%0h tag=%0h exp=1/1", req_ready_o, rsp_tag_o); end
        for (int c = 0; c < 40 && got < 6; c++) begin
            drive_req(next < 6, 3'd0, 2'(next), F24, F10, next);
            if (req_valid_i && req_ready_o) next++;
            if (rsp_valid_o) begin
                compared++; if (rsp_tag_o !== TAG_W'(got) || rsp_out_o !== 32'h4208_0000) begin mismatched++;
                    $display("FAIL bp_order got=%0h/%0h exp=%0h/42080000", rsp_tag_o, rsp_out_o, got); end
                got++;
            end
            advance();
        end
        req_valid_i = 1'b0;
        compared++; if (got !== 6 || next !== 6) begin mismatched++; $display("FAIL bp_no_loss got=%0d/%0d exp=6/6", got, next); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        int busy_seen;
        int n;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 3'd0, 2'd0, F24, F10, i + 7);
            advance();
        end
        req_valid_i = 1'b0;
        advance();
        compared++; if (busy_o !== 1'b1) begin mismatched++; $display("FAIL rstmid_busy_before got=%0h exp=1", busy_o); end
        rst_n = 1'b0;
        #1;
        compared++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin mismatched++;
            $display("FAIL rstmid_async got busy=%0h valid=%0h exp=0/0", busy_o, rsp_valid_o); end
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 2 * LAT + 4; c++) begin
            if (rsp_valid_o) seen++;
            if (busy_o) busy_seen++;
            advance();
        end
        compared++; if (seen !== 0 || busy_seen !== 0) begin mismatched++;
            $display("FAIL rstmid_quiet got valid_cycles=%0d busy_cycles=%0d exp=0/0", seen, busy_seen); end
        drive_req(1'b1, 3'd2, 2'd0, F24, F10, 6);
        advance();
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin advance(); n++; end
        compared++; if (rsp_valid_o !== 1'b1 || rsp_out_o !== 32'h4370_0000 || rsp_tag_o !== 4'd6) begin mismatched++;
            $display("FAIL rstmid_next got=%0h/%0h/%0h exp=1/43700000/6", rsp_valid_o, rsp_out_o, rsp_tag_o); end
        advance();
    endtask

    task automatic test_random();
        logic exp_v;
        for (int c = 0; c < 400; c++) begin
            if (c >= 370) begin
                drive_req(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 0);
                rsp_ready_i = 1'b1;
            end else begin
                drive_req($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          $urandom, $urandom, int'($urandom_range(0, 15)));
                rsp_ready_i = ((c / 40) % 3 == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
            end
            exp_v = exp_rsp_valid();
            compared++; if (rsp_valid_o !== exp_v) begin mismatched++; $display("FAIL rnd_rsp_valid c=%0d got=%0h exp=%0h", c, rsp_valid_o, exp_v); end
            if (exp_v) begin
                compared++; if (rsp_out_o !== q[0].out || rsp_flags_o !== q[0].flags || rsp_tag_o !== q[0].tag) begin mismatched++;
                    $display("FAIL rnd_rsp_data c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, rsp_out_o, rsp_flags_o, rsp_tag_o,
                             q[0].out, q[0].flags, q[0].tag); end
            end
            compared++; if (req_ready_o !== (q.size() < DEPTH)) begin mismatched++;
                $display("FAIL rnd_req_ready c=%0d got=%0h exp=%0h", c, req_ready_o, q.size() < DEPTH); end
            compared++; if (busy_o !== (q.size() != 0)) begin mismatched++;
                $display("FAIL rnd_busy c=%0d got=%0h exp=%0h", c, busy_o, q.size() != 0); end
            advance();
        end
        compared++; if (q.size() !== 0 || rsp_valid_o !== 1'b0) begin mismatched++;
            $display("FAIL rnd_drain got pending=%0d valid=%0h exp=0/0", q.size(), rsp_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_div_zero();
        test_illegal();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
